syscall_ctrl: RTL and testbench

Syscall controller: consumes the pending-syscall signals (`SYSCALL_trig`, `SYSCALL_num`, `SYSCALL_info`) from the syscall write port and queues each request in a small FIFO. It returns the one-cycle `SYSCALL_clr` acknowledge to that port and raises an interrupt to the CPU. It also exposes the queue as read/pop registers on the 8-bit Wishbone bus, which makes it the SYSCTRL register block of the SoC.

---
 rtl/syscall_ctrl_pkg.sv | 21 ++
 rtl/syscall_ctrl_if.sv | 30 +++
 rtl/syscall_fifo.sv | 57 +++++
 rtl/syscall_ctrl.sv | 107 ++++++++++
 tb/tb_syscall_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/syscall_ctrl_pkg.sv
// Shared constants and types for the SYSCTRL syscall controller block.
package syscall_ctrl_pkg;

    localparam logic [1:0] SC_ADDR_STATUS = 2'd0;
    localparam logic [1:0] SC_ADDR_NUM    = 2'd1;
    localparam logic [1:0] SC_ADDR_INFO   = 2'd2;
    localparam logic [1:0] SC_ADDR_CTRL   = 2'd3;

    localparam int unsigned SC_STATUS_NE   = 0;
    localparam int unsigned SC_STATUS_FULL = 1;
    localparam int unsigned SC_STATUS_HELD = 2;

    localparam int unsigned SC_CTRL_IE  = 0;
    localparam int unsigned SC_CTRL_POP = 7;

    typedef enum logic {
        StIdle,
        StClr
    } cap_state_e;

endpackage

// File: rtl/syscall_ctrl_if.sv
// Syscall write port and 8-bit Wishbone slave signals of the SYSCTRL block.
interface syscall_ctrl_if;

    logic       SYSCALL_trig;
    logic [7:0] SYSCALL_num;
    logic [7:0] SYSCALL_info;
    logic       SYSCALL_clr;
    logic       IRQ;

    logic [7:0] WB_ADRi;
    logic [7:0] WB_DATi;
    logic [7:0] WB_DATo;
    logic       WB_WEi;
    logic       WB_CYCi;
    logic       WB_STBi;
    logic       WB_ACKo;

    modport master (
        output SYSCALL_trig, SYSCALL_num, SYSCALL_info,
        output WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
        input  SYSCALL_clr, IRQ, WB_DATo, WB_ACKo
    );

    modport slave (
        input  SYSCALL_trig, SYSCALL_num, SYSCALL_info,
        input  WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
        output SYSCALL_clr, IRQ, WB_DATo, WB_ACKo
    );

endinterface

// File: rtl/syscall_fifo.sv
// Synchronous 16-bit FIFO; push when full and pop when empty are ignored.
module syscall_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [15:0]              i_data,
    output logic [15:0]              o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/syscall_ctrl.sv
// Syscall controller: queues upstream syscall requests, acks them with a clr
// pulse, raises IRQ and exposes the queue as Wishbone registers.
module syscall_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    syscall_ctrl_if.slave  bus
);

    import syscall_ctrl_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    cap_state_e  r_state;
    logic        r_clr;
    logic        r_ack;
    logic [7:0]  r_dat;
    logic        r_ie;
    logic        r_irq;

    logic        w_push;
    logic        w_pop;
    logic        w_wb_req;
    logic        w_wr_ctrl;
    logic [1:0]  w_adr;
    logic [15:0] w_head;
    logic [CW-1:0] w_count;
    logic [3:0]  w_cnt4;
    logic        w_full;
    logic        w_empty;
    logic        w_held;
    logic [7:0]  w_rdata;
    logic        w_unused;

    assign w_adr     = bus.WB_ADRi[1:0];
    assign w_wb_req  = bus.WB_CYCi & bus.WB_STBi & ~r_ack;
    assign w_wr_ctrl = w_wb_req & bus.WB_WEi & (w_adr == SC_ADDR_CTRL);
    assign w_pop     = w_wr_ctrl & bus.WB_DATi[SC_CTRL_POP];
    assign w_push    = (r_state == StIdle) & bus.SYSCALL_trig & ~w_full;
    assign w_held    = bus.SYSCALL_trig & w_full;
    assign w_cnt4    = 4'(w_count);
    assign w_unused  = ^{bus.WB_ADRi[7:2], bus.WB_DATi[6:1]};

    syscall_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({bus.SYSCALL_num, bus.SYSCALL_info}),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_clr   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_clr <= w_push;
                    if (w_push) r_state <= StClr;
                end
                default: begin
                    r_clr   <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (w_adr)
            SC_ADDR_STATUS: w_rdata = {w_cnt4, 1'b0, w_held, w_full, ~w_empty};
            SC_ADDR_NUM:    w_rdata = w_empty ? 8'h00 : w_head[15:8];
            SC_ADDR_INFO:   w_rdata = w_empty ? 8'h00 : w_head[7:0];
            default:        w_rdata = {7'b0, r_ie};
        endcase
    end

    // Every accepted request is acked one cycle, forcing ACK low in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack <= 1'b0;
            r_dat <= 8'h00;
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ie & ~w_empty;
            r_ack <= w_wb_req;
            if (w_wb_req) r_dat <= w_rdata;
            if (w_wr_ctrl) r_ie <= bus.WB_DATi[SC_CTRL_IE];
        end
    end

    assign bus.SYSCALL_clr = r_clr;
    assign bus.IRQ         = r_irq;
    assign bus.WB_ACKo     = r_ack;
    assign bus.WB_DATo     = r_dat;

endmodule

// File: tb/tb_syscall_ctrl.sv
// Scoreboard bench for syscall_ctrl: reads queue expected data, monitor checks on ACK.
module tb_syscall_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   clr_cnt;

    syscall_ctrl_if bus ();

    syscall_ctrl #(
        .DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       chk;
        logic [7:0] d;
        string      nm;
    } sb_t;

    sb_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Upstream model: trig stays pending until the clr pulse is seen.
    always @(negedge clk) begin
        if (bus.SYSCALL_clr) begin
            clr_cnt++;
            bus.SYSCALL_trig = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.WB_ACKo) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard");
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (e.chk) begin
                    checks++;
                    if (bus.WB_DATo !== e.d) begin
                        errors++;
                        $display("FAIL %s: got 0x%02h, expected 0x%02h", e.nm, bus.WB_DATo, e.d);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [1:0] a, input logic [7:0] d,
                      input logic c, input logic [7:0] e, input string nm);
        sb_t s;
        @(negedge clk);
        bus.WB_CYCi = 1'b1;
        bus.WB_STBi = 1'b1;
        bus.WB_WEi  = we;
        bus.WB_ADRi = {6'($urandom), a};
        bus.WB_DATi = d;
        s.chk = c;
        s.d   = e;
        s.nm  = nm;
        sb.push_back(s);
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.WB_CYCi = 1'b0;
        bus.WB_STBi = 1'b0;
        bus.WB_WEi  = 1'b0;
        chk({nm, "_ack"}, 8'(sb.size()), 8'd0);
        sb.delete();
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e, input string nm);
        wb(1'b0, a, 8'h00, 1'b1, e, nm);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input string nm);
        wb(1'b1, a, d, 1'b0, 8'h00, nm);
    endtask

    task automatic raise(input logic [7:0] n, input logic [7:0] i);
        @(negedge clk);
        #1;
        bus.SYSCALL_trig = 1'b1;
        bus.SYSCALL_num  = n;
        bus.SYSCALL_info = i;
    endtask

    task automatic wait_capture(input string nm);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #2;
            if (!bus.SYSCALL_trig) break;
        end
        chk(nm, {7'b0, bus.SYSCALL_trig}, 8'h00);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clr_cnt = 0;
        rst = 1'b1;
        bus.SYSCALL_trig = 1'b0;
        bus.SYSCALL_num  = 8'h00;
        bus.SYSCALL_info = 8'h00;
        bus.WB_ADRi = 8'h00;
        bus.WB_DATi = 8'h00;
        bus.WB_WEi  = 1'b0;
        bus.WB_CYCi = 1'b0;
        bus.WB_STBi = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_clr", {7'b0, bus.SYSCALL_clr}, 8'h00);
        chk("rst_irq", {7'b0, bus.IRQ}, 8'h00);
        chk("rst_ack", {7'b0, bus.WB_ACKo}, 8'h00);
        chk("rst_dat", bus.WB_DATo, 8'h00);
        rd(2'd0, 8'h00, "rst_status");
        rd(2'd3, 8'h00, "rst_ctrl");

        // Single request with interrupt enabled.
        wr(2'd3, 8'h01, "wr_ie");
        rd(2'd3, 8'h01, "ctrl_ie");
        raise(8'h12, 8'h34);
        wait_capture("cap1");
        @(negedge clk);
        #1;
        chk("irq_set", {7'b0, bus.IRQ}, 8'h01);
        chk("clr_once", 8'(clr_cnt), 8'd1);
        rd(2'd0, 8'h11, "status1");
        rd(2'd1, 8'h12, "num1");
        rd(2'd2, 8'h34, "info1");
        wr(2'd3, 8'h81, "pop1");
        @(negedge clk);
        #1;
        chk("irq_drop", {7'b0, bus.IRQ}, 8'h00);
        rd(2'd0, 8'h00, "status_empty");
        rd(2'd1, 8'h00, "num_empty");

        // Fill to full, then hold the fifth request.
        clr_cnt = 0;
        for (int n = 1; n <= 4; n++) begin
            raise(8'(n), 8'(n + 16));
            wait_capture("cap_fill");
        end
        rd(2'd0, 8'h43, "status_full");
        raise(8'h05, 8'h15);
        repeat (4) @(negedge clk);
        #1;
        chk("held_trig", {7'b0, bus.SYSCALL_trig}, 8'h01);
        chk("held_noclr", 8'(clr_cnt), 8'd4);
        rd(2'd0, 8'h47, "status_held");
        wr(2'd3, 8'h81, "pop_full");
        wait_capture("cap_held");
        chk("held_clr", 8'(clr_cnt), 8'd5);
        rd(2'd0, 8'h43, "status_after_held");
        rd(2'd1, 8'h02, "num_head2");
        rd(2'd2, 8'h12, "info_head2");

        // Drain to a single entry (num=5).
        repeat (3) wr(2'd3, 8'h81, "pop_drain");
        rd(2'd0, 8'h11, "status_one");
        rd(2'd1, 8'h05, "num_one");

        // Push and pop on the same edge with count=1.
        begin
            sb_t s;
            @(negedge clk);
            #1;
            bus.SYSCALL_trig = 1'b1;
            bus.SYSCALL_num  = 8'hAA;
            bus.SYSCALL_info = 8'hBB;
            bus.WB_CYCi = 1'b1;
            bus.WB_STBi = 1'b1;
            bus.WB_WEi  = 1'b1;
            bus.WB_ADRi = 8'h03;
            bus.WB_DATi = 8'h81;
            s.chk = 1'b0;
            s.d   = 8'h00;
            s.nm  = "pushpop";
            sb.push_back(s);
            @(posedge clk);
            @(negedge clk);
            #1;
            bus.WB_CYCi = 1'b0;
            bus.WB_STBi = 1'b0;
            bus.WB_WEi  = 1'b0;
            chk("pushpop_ack", 8'(sb.size()), 8'd0);
            chk("pushpop_cap", {7'b0, bus.SYSCALL_trig}, 8'h00);
            sb.delete();
        end
        rd(2'd1, 8'hAA, "num_pushpop");
        rd(2'd2, 8'hBB, "info_pushpop");
        rd(2'd0, 8'h11, "status_pushpop");

        // Pop to empty, then pop again on empty.
        wr(2'd3, 8'h81, "pop_last");
        rd(2'd0, 8'h00, "status_drained");
        wr(2'd3, 8'h81, "pop_on_empty");
        rd(2'd0, 8'h00, "status_pop_empty");

        // Reset during CLR with three entries queued.
        raise(8'h21, 8'h01);
        wait_capture("cap_r1");
        raise(8'h22, 8'h02);
        wait_capture("cap_r2");
        raise(8'h23, 8'h03);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                #1;
                if (bus.SYSCALL_clr) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("clr_before_rst", {7'b0, seen}, 8'h01);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mid_clr", {7'b0, bus.SYSCALL_clr}, 8'h00);
        rst = 1'b0;
        rd(2'd0, 8'h00, "status_after_rst");
        rd(2'd3, 8'h00, "ctrl_after_rst");
        chk("irq_after_rst", {7'b0, bus.IRQ}, 8'h00);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
